// File: rtl/mesi_isc_cpu_agent_if.sv
// rtl/mesi_isc_cpu_agent_if.sv - CPU, main-bus and coherence-bus signals of one MESI CPU agent
interface mesi_isc_cpu_agent_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3
);
  logic                      cpu_req_i;
  logic                      cpu_we_i;
  logic [ADDR_WIDTH-1:0]     cpu_addr_i;
  logic                      cpu_ack_o;
  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o;
  logic [ADDR_WIDTH-1:0]     mbus_addr_o;
  logic                      mbus_ack_i;
  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i;
  logic [ADDR_WIDTH-1:0]     cbus_addr_i;
  logic                      cbus_ack_o;
  logic                      busy_o;

  // Agent side.
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, mbus_ack_i, cbus_cmd_i, cbus_addr_i,
    output cpu_ack_o, mbus_cmd_o, mbus_addr_o, cbus_ack_o, busy_o
  );

  // CPU / controller side.
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, mbus_ack_i, cbus_cmd_i, cbus_addr_i,
    input  cpu_ack_o, mbus_cmd_o, mbus_addr_o, cbus_ack_o, busy_o
  );
endinterface

// File: rtl/mesi_isc_cpu_agent.sv
// rtl/mesi_isc_cpu_agent.sv - MESI CPU agent: direct-mapped line tracker, main FSM and snoop FSM
module mesi_isc_cpu_agent #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int LINES          = 4,
  parameter int LINES_LOG2     = 2
) (
  input logic                 clk,
  input logic                 rst,
  mesi_isc_cpu_agent_if.slave bus
);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_NOP      = MBUS_CMD_WIDTH'(0);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR       = MBUS_CMD_WIDTH'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD       = MBUS_CMD_WIDTH'(2);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] MB_RD_BROAD = MBUS_CMD_WIDTH'(4);

  localparam logic [CBUS_CMD_WIDTH-1:0] CB_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CB_EN_RD    = CBUS_CMD_WIDTH'(4);

  typedef enum logic [1:0] {L_I, L_S, L_E, L_M} line_e;
  typedef enum logic [2:0] {IDLE, BREQ, WAIT_EN, ACC, DONE} main_e;
  typedef enum logic [1:0] {SIDLE, SWB, SACK, SNOP} snp_e;

  logic [ADDR_WIDTH-1:0]     tag_q [LINES];
  line_e                     st_q  [LINES];
  logic [ADDR_WIDTH-1:0]     pend_addr_q;
  logic                      pend_we_q;
  logic [CBUS_CMD_WIDTH-1:0] snp_cmd_q;
  logic [ADDR_WIDTH-1:0]     snp_addr_q;

  main_e main_q, main_d;
  snp_e  snp_q, snp_d;

  logic [LINES_LOG2-1:0] cpu_idx, cbus_idx, pend_idx, snp_idx;
  logic cpu_hit, cpu_fast, cbus_hit, cbus_is_snoop, snp_to_swb;
  logic main_owns, swb_done, en_match, cpu_fast_write, acc_done, snp_start;

  assign cpu_idx  = bus.cpu_addr_i[LINES_LOG2-1:0];
  assign cbus_idx = bus.cbus_addr_i[LINES_LOG2-1:0];
  assign pend_idx = pend_addr_q[LINES_LOG2-1:0];
  assign snp_idx  = snp_addr_q[LINES_LOG2-1:0];

  assign cpu_hit  = (tag_q[cpu_idx] == bus.cpu_addr_i) && (st_q[cpu_idx] != L_I);
  // A write to a shared line must still gain ownership over the bus.
  assign cpu_fast = cpu_hit && (!bus.cpu_we_i || st_q[cpu_idx] == L_E || st_q[cpu_idx] == L_M);

  assign cbus_hit      = (tag_q[cbus_idx] == bus.cbus_addr_i) && (st_q[cbus_idx] != L_I);
  assign cbus_is_snoop = (bus.cbus_cmd_i == CB_WR_SNOOP) || (bus.cbus_cmd_i == CB_RD_SNOOP);
  assign snp_start     = (snp_q == SIDLE) && (bus.cbus_cmd_i != CB_NOP);
  assign snp_to_swb    = snp_start && cbus_is_snoop && cbus_hit && (st_q[cbus_idx] == L_M);

  assign main_owns = (main_q == BREQ) || (main_q == ACC);
  assign swb_done  = (snp_q == SWB) && !main_owns && bus.mbus_ack_i;
  assign en_match  = (snp_q == SACK) && ((snp_cmd_q == CB_EN_WR) || (snp_cmd_q == CB_EN_RD))
                     && (snp_addr_q == pend_addr_q);
  assign cpu_fast_write = (main_q == IDLE) && bus.cpu_req_i && cpu_fast && bus.cpu_we_i;
  assign acc_done       = (main_q == ACC) && bus.mbus_ack_i;

  // Main FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) main_q <= IDLE;
    else     main_q <= main_d;
  end

  // Main FSM: next state. A pending or same-cycle write-back keeps us out of BREQ.
  always_comb begin
    main_d = main_q;
    case (main_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (cpu_fast)                              main_d = DONE;
          else if (!(snp_q == SWB || snp_to_swb))    main_d = BREQ;
        end
      end
      BREQ:    if (bus.mbus_ack_i) main_d = WAIT_EN;
      WAIT_EN: if (en_match)       main_d = ACC;
      ACC:     if (bus.mbus_ack_i) main_d = DONE;
      DONE:    main_d = IDLE;
      default: main_d = IDLE;
    endcase
  end

  // Snoop FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) snp_q <= SIDLE;
    else     snp_q <= snp_d;
  end

  // Snoop FSM: next state.
  always_comb begin
    snp_d = snp_q;
    case (snp_q)
      SIDLE:   if (snp_start) snp_d = snp_to_swb ? SWB : SACK;
      SWB:     if (swb_done)  snp_d = SACK;
      SACK:    snp_d = SNOP;
      SNOP:    if (bus.cbus_cmd_i == CB_NOP) snp_d = SIDLE;
      default: snp_d = SIDLE;
    endcase
  end

  // Outputs of both FSMs; the main FSM has priority on the main bus.
  always_comb begin
    bus.cpu_ack_o   = (main_q == DONE);
    bus.busy_o      = (main_q != IDLE);
    bus.cbus_ack_o  = (snp_q == SACK);
    bus.mbus_cmd_o  = MB_NOP;
    bus.mbus_addr_o = '0;
    if (main_q == BREQ) begin
      bus.mbus_cmd_o  = pend_we_q ? MB_WR_BROAD : MB_RD_BROAD;
      bus.mbus_addr_o = pend_addr_q;
    end else if (main_q == ACC) begin
      bus.mbus_cmd_o  = pend_we_q ? MB_WR : MB_RD;
      bus.mbus_addr_o = pend_addr_q;
    end else if (snp_q == SWB) begin
      bus.mbus_cmd_o  = MB_WR;
      bus.mbus_addr_o = snp_addr_q;
    end
  end

  // Request/snoop capture and line storage. Main-FSM updates come last so they win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LINES; i++) begin
        st_q[i]  <= L_I;
        tag_q[i] <= '0;
      end
      pend_addr_q <= '0;
      pend_we_q   <= 1'b0;
      snp_cmd_q   <= CB_NOP;
      snp_addr_q  <= '0;
    end else begin
      if (main_q == IDLE && bus.cpu_req_i) begin
        pend_addr_q <= bus.cpu_addr_i;
        pend_we_q   <= bus.cpu_we_i;
      end
      if (snp_start) begin
        snp_cmd_q  <= bus.cbus_cmd_i;
        snp_addr_q <= bus.cbus_addr_i;
        if (cbus_hit && st_q[cbus_idx] != L_M) begin
          if (bus.cbus_cmd_i == CB_WR_SNOOP)
            st_q[cbus_idx] <= L_I;
          else if (bus.cbus_cmd_i == CB_RD_SNOOP && st_q[cbus_idx] == L_E)
            st_q[cbus_idx] <= L_S;
        end
      end
      // The line may have been replaced while the write-back waited for the bus.
      if (swb_done && tag_q[snp_idx] == snp_addr_q)
        st_q[snp_idx] <= (snp_cmd_q == CB_WR_SNOOP) ? L_I : L_S;
      if (cpu_fast_write)
        st_q[cpu_idx] <= L_M;
      if (acc_done) begin
        tag_q[pend_idx] <= pend_addr_q;
        st_q[pend_idx]  <= pend_we_q ? L_M : L_S;
      end
    end
  end
endmodule

// File: tb/tb_mesi_isc_cpu_agent.sv
// tb/tb_mesi_isc_cpu_agent.sv - directed bench for mesi_isc_cpu_agent
module tb_mesi_isc_cpu_agent;
  localparam int AW = 32;
  localparam logic [63:0] LI = 0, LS = 1, LM = 3;
  localparam logic [63:0] M_NOP = 0, M_WR = 1, M_RD = 2, M_WRB = 3, M_RDB = 4;
  localparam logic [2:0]  C_NOP = 0, C_WRS = 1, C_RDS = 2, C_ENW = 3, C_ENR = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  mesi_isc_cpu_agent_if #(.ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3)) bif ();

  mesi_isc_cpu_agent #(
    .ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3), .LINES(4), .LINES_LOG2(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full miss transaction with every handshake acked at the first opportunity.
  task automatic miss_txn(input logic [AW-1:0] a, input logic we);
    bif.cpu_req_i = 1'b1; bif.cpu_we_i = we; bif.cpu_addr_i = a;
    step();
    bif.cpu_req_i = 1'b0;
    chk("txn_broad", bif.mbus_cmd_o, we ? M_WRB : M_RDB);
    bif.mbus_ack_i = 1'b1; step(); bif.mbus_ack_i = 1'b0;
    bif.cbus_cmd_i = we ? C_ENW : C_ENR; bif.cbus_addr_i = a;
    step();
    chk("txn_en_ack", bif.cbus_ack_o, 1);
    bif.cbus_cmd_i = C_NOP;
    step();
    chk("txn_acc", bif.mbus_cmd_o, we ? M_WR : M_RD);
    bif.mbus_ack_i = 1'b1; step(); bif.mbus_ack_i = 1'b0;
    chk("txn_cpu_ack", bif.cpu_ack_o, 1);
    step();
  endtask

  initial begin
    bif.cpu_req_i = 0; bif.cpu_we_i = 0; bif.cpu_addr_i = '0;
    bif.mbus_ack_i = 0; bif.cbus_cmd_i = C_NOP; bif.cbus_addr_i = '0;

    // Reset state
    step(); step();
    chk("rst_mbus_cmd", bif.mbus_cmd_o, M_NOP);
    chk("rst_mbus_addr", bif.mbus_addr_o, 0);
    chk("rst_cbus_ack", bif.cbus_ack_o, 0);
    chk("rst_cpu_ack", bif.cpu_ack_o, 0);
    chk("rst_busy", bif.busy_o, 0);
    chk("rst_line0", dut.st_q[0], LI);
    rst = 1'b0;
    step();

    // Read miss at 0x10
    bif.cpu_req_i = 1; bif.cpu_we_i = 0; bif.cpu_addr_i = 32'h10;
    step();
    bif.cpu_req_i = 0;
    chk("rm_rdb", bif.mbus_cmd_o, M_RDB);
    chk("rm_rdb_addr", bif.mbus_addr_o, 32'h10);
    chk("rm_busy", bif.busy_o, 1);
    step();
    chk("rm_rdb_hold", bif.mbus_cmd_o, M_RDB);
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    chk("rm_nop_after_ack", bif.mbus_cmd_o, M_NOP);
    bif.cbus_cmd_i = C_ENR; bif.cbus_addr_i = 32'h10;
    step();
    chk("rm_cbus_ack", bif.cbus_ack_o, 1);
    bif.cbus_cmd_i = C_NOP;
    step();
    chk("rm_cbus_ack_once", bif.cbus_ack_o, 0);
    chk("rm_rd", bif.mbus_cmd_o, M_RD);
    chk("rm_rd_addr", bif.mbus_addr_o, 32'h10);
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    chk("rm_cpu_ack", bif.cpu_ack_o, 1);
    chk("rm_line0_s", dut.st_q[0], LS);
    chk("rm_tag0", dut.tag_q[0], 32'h10);
    step();
    chk("rm_cpu_ack_pulse", bif.cpu_ack_o, 0);
    chk("rm_idle", bif.busy_o, 0);

    // Write hit in S at 0x10
    bif.cpu_req_i = 1; bif.cpu_we_i = 1; bif.cpu_addr_i = 32'h10;
    step();
    bif.cpu_req_i = 0;
    chk("ws_wrb", bif.mbus_cmd_o, M_WRB);
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    bif.cbus_cmd_i = C_ENW; bif.cbus_addr_i = 32'h10;
    step();
    chk("ws_cbus_ack", bif.cbus_ack_o, 1);
    bif.cbus_cmd_i = C_NOP;
    step();
    chk("ws_wr", bif.mbus_cmd_o, M_WR);
    chk("ws_wr_addr", bif.mbus_addr_o, 32'h10);
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    chk("ws_cpu_ack", bif.cpu_ack_o, 1);
    chk("ws_line0_m", dut.st_q[0], LM);
    step();

    // Second write hits M: ack next cycle, no bus traffic
    bif.cpu_req_i = 1; bif.cpu_we_i = 1; bif.cpu_addr_i = 32'h10;
    step();
    bif.cpu_req_i = 0;
    chk("wm_cpu_ack", bif.cpu_ack_o, 1);
    chk("wm_no_bus", bif.mbus_cmd_o, M_NOP);
    step();
    chk("wm_idle", bif.busy_o, 0);

    // RD_SNOOP to the modified line, command held for 3 cycles
    bif.cbus_cmd_i = C_RDS; bif.cbus_addr_i = 32'h10;
    step();
    chk("rs_wb", bif.mbus_cmd_o, M_WR);
    chk("rs_wb_addr", bif.mbus_addr_o, 32'h10);
    chk("rs_no_early_ack", bif.cbus_ack_o, 0);
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    chk("rs_cbus_ack", bif.cbus_ack_o, 1);
    chk("rs_line0_s", dut.st_q[0], LS);
    step();
    chk("rs_single_ack", bif.cbus_ack_o, 0);
    bif.cbus_cmd_i = C_NOP;
    step();
    chk("rs_no_reack", bif.cbus_ack_o, 0);

    // Snoop miss at 0x24
    bif.cbus_cmd_i = C_WRS; bif.cbus_addr_i = 32'h24;
    step();
    chk("sm_cbus_ack", bif.cbus_ack_o, 1);
    chk("sm_no_bus", bif.mbus_cmd_o, M_NOP);
    bif.cbus_cmd_i = C_NOP;
    step(); step();
    chk("sm_line0_same", dut.st_q[0], LS);
    chk("sm_tag0_same", dut.tag_q[0], 32'h10);

    // Contention: WR_SNOOP 0x20 arrives while WR_BROAD 0x30 waits
    miss_txn(32'h20, 1'b1);
    chk("ct_line0_m", dut.st_q[0], LM);
    bif.cpu_req_i = 1; bif.cpu_we_i = 1; bif.cpu_addr_i = 32'h30;
    step();
    bif.cpu_req_i = 0;
    bif.cbus_cmd_i = C_WRS; bif.cbus_addr_i = 32'h20;
    step();
    chk("ct_broad_kept", bif.mbus_cmd_o, M_WRB);
    chk("ct_broad_addr", bif.mbus_addr_o, 32'h30);
    step();
    chk("ct_broad_hold", bif.mbus_cmd_o, M_WRB);
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    chk("ct_wb", bif.mbus_cmd_o, M_WR);
    chk("ct_wb_addr", bif.mbus_addr_o, 32'h20);
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    chk("ct_snoop_ack", bif.cbus_ack_o, 1);
    chk("ct_line0_i", dut.st_q[0], LI);
    bif.cbus_cmd_i = C_NOP;
    step(); step();
    bif.cbus_cmd_i = C_ENW; bif.cbus_addr_i = 32'h30;
    step();
    chk("ct_en_ack", bif.cbus_ack_o, 1);
    bif.cbus_cmd_i = C_NOP;
    step();
    chk("ct_acc", bif.mbus_cmd_o, M_WR);
    chk("ct_acc_addr", bif.mbus_addr_o, 32'h30);
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    chk("ct_cpu_ack", bif.cpu_ack_o, 1);
    chk("ct_line0_m2", dut.st_q[0], LM);
    chk("ct_tag0", dut.tag_q[0], 32'h30);
    step();

    // Same-cycle write-back beats a new miss
    bif.cpu_req_i = 1; bif.cpu_we_i = 0; bif.cpu_addr_i = 32'h05;
    bif.cbus_cmd_i = C_RDS; bif.cbus_addr_i = 32'h30;
    step();
    chk("sc_wb_first", bif.mbus_cmd_o, M_WR);
    chk("sc_wb_addr", bif.mbus_addr_o, 32'h30);
    chk("sc_main_idle", bif.busy_o, 0);
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    chk("sc_snoop_ack", bif.cbus_ack_o, 1);
    chk("sc_still_idle", bif.mbus_cmd_o, M_NOP);
    chk("sc_line0_s", dut.st_q[0], LS);
    bif.cbus_cmd_i = C_NOP;
    step();
    bif.cpu_req_i = 0;
    chk("sc_rdb", bif.mbus_cmd_o, M_RDB);
    chk("sc_rdb_addr", bif.mbus_addr_o, 32'h05);

    // Reset while waiting for enable
    bif.mbus_ack_i = 1; step(); bif.mbus_ack_i = 0;
    chk("rw_wait_en_busy", bif.busy_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_mbus_cmd", bif.mbus_cmd_o, M_NOP);
    chk("rw_mbus_addr", bif.mbus_addr_o, 0);
    chk("rw_cbus_ack", bif.cbus_ack_o, 0);
    chk("rw_cpu_ack", bif.cpu_ack_o, 0);
    chk("rw_busy", bif.busy_o, 0);
    for (int i = 0; i < 4; i++) chk("rw_line_i", dut.st_q[i], LI);
    bif.cbus_cmd_i = C_ENR; bif.cbus_addr_i = 32'h05;
    step();
    bif.cbus_cmd_i = C_NOP;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_no_cpu_ack", bif.cpu_ack_o, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
